usb_host_reg_seq: RTL and testbench

Register-access sequencer upstream of the USB host wrapper. Drives the wrapper's 8-bit address/data/we/strobe bus and waits for its ack. Accepts single register read/write requests from a controller over a valid/ready channel and returns each result over a response channel. Adds a bus timeout and an optional interrupt-status fetch.

---
 rtl/usb_host_reg_seq.sv | 198 +++++++++++++++++++
 tb/tb_usb_host_reg_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_host_reg_seq.sv
// rtl/usb_host_reg_seq.sv - register-access sequencer driving the USB host wrapper bus
// Optional interrupt-status fetch is built in when USB_REG_SEQ_IRQ_FETCH_EN is defined.
module usb_host_reg_seq #(
  parameter int unsigned TIMEOUT_CYCLES  = 255,
  parameter int unsigned TO_WIDTH        = 8,
  parameter logic [7:0]  IRQ_STATUS_ADDR = 8'h09
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [7:0] req_addr_i,
  input  logic [7:0] req_data_i,
  input  logic       req_we_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] rsp_data_o,
  output logic       rsp_err_o,
  output logic [7:0] address_o,
  output logic [7:0] data_o,
  input  logic [7:0] data_i,
  output logic       we_o,
  output logic       strobe_o,
  input  logic       ack_i,
  input  logic       irq_i,
  output logic [7:0] irq_status_o,
  output logic       irq_status_valid_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_RESP   = 3'd2
`ifdef USB_REG_SEQ_IRQ_FETCH_EN
    ,
    S_IRQ_RD = 3'd3,
    S_IRQ_WR = 3'd4
`endif
  } state_t;

  localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [TO_WIDTH-1:0] TO_ONE   = TO_WIDTH'(1);

  state_t              state_q, state_d;
  logic [TO_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0]          address_q, address_d, data_q, data_d, rsp_data_q, rsp_data_d;
  logic                we_q, we_d, strobe_q, strobe_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [7:0]          irq_status_q, irq_status_d;
  logic                irq_status_valid_q, irq_status_valid_d;
  logic                timeout;

  // Ack on the cycle the count would hit the limit still wins over the timeout.
  assign cnt_inc = cnt_q + TO_ONE;
  assign timeout = !ack_i && (cnt_inc == TO_LIMIT);

`ifndef USB_REG_SEQ_IRQ_FETCH_EN
  logic unused_irq;
  assign unused_irq = ^{irq_i, IRQ_STATUS_ADDR};
`endif

  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    address_d          = address_q;
    data_d             = data_q;
    we_d               = we_q;
    strobe_d           = strobe_q;
    rsp_valid_d        = rsp_valid_q;
    rsp_data_d         = rsp_data_q;
    rsp_err_d          = rsp_err_q;
    irq_status_d       = irq_status_q;
    irq_status_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          address_d = req_addr_i;
          data_d    = req_data_i;
          we_d      = req_we_i;
          strobe_d  = 1'b1;
          cnt_d     = '0;
          state_d   = S_ACCESS;
        end
`ifdef USB_REG_SEQ_IRQ_FETCH_EN
        else if (irq_i) begin
          address_d = IRQ_STATUS_ADDR;
          data_d    = 8'h00;
          we_d      = 1'b0;
          strobe_d  = 1'b1;
          cnt_d     = '0;
          state_d   = S_IRQ_RD;
        end
`endif
      end
      S_ACCESS: begin
        if (ack_i) begin
          strobe_d    = 1'b0;
          rsp_data_d  = we_q ? 8'h00 : data_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (timeout) begin
          strobe_d    = 1'b0;
          rsp_data_d  = 8'hFF;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end
      end
`ifdef USB_REG_SEQ_IRQ_FETCH_EN
      S_IRQ_RD: begin
        if (ack_i) begin
          strobe_d = 1'b0;
          data_d   = data_i;
          we_d     = 1'b1;
          cnt_d    = '0;
          state_d  = S_IRQ_WR;
        end else if (timeout) begin
          strobe_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_IRQ_WR: begin
        // First cycle here is the mandatory strobe-low gap after the read ack.
        if (!strobe_q) begin
          strobe_d = 1'b1;
        end else if (ack_i) begin
          strobe_d           = 1'b0;
          irq_status_d       = data_q;
          irq_status_valid_d = 1'b1;
          cnt_d              = '0;
          state_d            = S_IDLE;
        end else if (timeout) begin
          strobe_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q            <= S_IDLE;
      cnt_q              <= '0;
      address_q          <= 8'h00;
      data_q             <= 8'h00;
      we_q               <= 1'b0;
      strobe_q           <= 1'b0;
      rsp_valid_q        <= 1'b0;
      rsp_data_q         <= 8'h00;
      rsp_err_q          <= 1'b0;
      irq_status_q       <= 8'h00;
      irq_status_valid_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      address_q          <= address_d;
      data_q             <= data_d;
      we_q               <= we_d;
      strobe_q           <= strobe_d;
      rsp_valid_q        <= rsp_valid_d;
      rsp_data_q         <= rsp_data_d;
      rsp_err_q          <= rsp_err_d;
      irq_status_q       <= irq_status_d;
      irq_status_valid_q <= irq_status_valid_d;
    end
  end

  assign req_ready_o        = (state_q == S_IDLE);
  assign busy_o             = (state_q != S_IDLE);
  assign rsp_valid_o        = rsp_valid_q;
  assign rsp_data_o         = rsp_data_q;
  assign rsp_err_o          = rsp_err_q;
  assign address_o          = address_q;
  assign data_o             = data_q;
  assign we_o               = we_q;
  assign strobe_o           = strobe_q;
  assign irq_status_o       = irq_status_q;
  assign irq_status_valid_o = irq_status_valid_q;

endmodule

// File: tb/tb_usb_host_reg_seq.sv
// tb/tb_usb_host_reg_seq.sv - self-checking bench for usb_host_reg_seq with a behavioural wrapper model
// Covers the IRQ fetch scenarios when USB_REG_SEQ_IRQ_FETCH_EN is defined.
module tb_usb_host_reg_seq;
  localparam int TO = 4;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       req_valid_i = 1'b0, req_ready_o, req_we_i = 1'b0;
  logic [7:0] req_addr_i = 8'h00, req_data_i = 8'h00;
  logic       rsp_valid_o, rsp_ready_i = 1'b0, rsp_err_o;
  logic [7:0] rsp_data_o, address_o, data_o, data_i = 8'h00, irq_status_o;
  logic       we_o, strobe_o, ack_i = 1'b0, irq_i = 1'b0, irq_status_valid_o, busy_o;

  int vectors = 0;
  int miscompares = 0;

  // Observations from the last run_txn call
  logic [7:0] r_data;
  logic       r_err, r_ready_at_req, r_stable_bad, r_hold_bad, r_after_bad, r_hung;
  int         r_scount, r_lat, r_rises;

  always #5 clk_i = ~clk_i;

  usb_host_reg_seq #(.TIMEOUT_CYCLES(TO), .TO_WIDTH(8), .IRQ_STATUS_ADDR(8'h09)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_data_i(req_data_i), .req_we_i(req_we_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .address_o(address_o), .data_o(data_o), .data_i(data_i), .we_o(we_o), .strobe_o(strobe_o),
    .ack_i(ack_i), .irq_i(irq_i), .irq_status_o(irq_status_o),
    .irq_status_valid_o(irq_status_valid_o), .busy_o(busy_o)
  );

  // Wrapper model: acks during the ack_lat-th strobe-high cycle (0 = never acks).
  task automatic run_txn(input logic [7:0] addr, input logic [7:0] wdata, input logic we,
                         input int ack_lat, input logic [7:0] rdata, input int ready_delay);
    logic seen, prev_s;
    r_scount = 0; r_lat = 0; r_rises = 0;
    r_stable_bad = 1'b0; r_hold_bad = 1'b0; r_after_bad = 1'b0; r_hung = 1'b0;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_addr_i = addr; req_data_i = wdata; req_we_i = we; data_i = rdata;
    r_ready_at_req = req_ready_o;
    seen = 1'b0; prev_s = 1'b0;
    for (int it = 1; it <= 400 && !seen; it++) begin
      @(negedge clk_i);
      req_valid_i = 1'b0; req_addr_i = 8'($urandom); req_data_i = 8'($urandom); req_we_i = 1'($urandom);
      if (rsp_valid_o) begin
        seen = 1'b1; r_lat = it;
      end else begin
        if (strobe_o) begin
          if (!prev_s) r_rises++;
          r_scount++;
          if (address_o !== addr || data_o !== wdata || we_o !== we || !busy_o || req_ready_o)
            r_stable_bad = 1'b1;
        end
        prev_s = strobe_o;
        ack_i = strobe_o && (r_scount == ack_lat);
      end
    end
    ack_i = 1'b0;
    if (!seen) begin
      r_hung = 1'b1;
      return;
    end
    r_data = rsp_data_o; r_err = rsp_err_o;
    if (strobe_o) r_stable_bad = 1'b1;
    repeat (ready_delay) begin
      @(negedge clk_i);
      if (!rsp_valid_o || rsp_data_o !== r_data || rsp_err_o !== r_err || req_ready_o || strobe_o || !busy_o)
        r_hold_bad = 1'b1;
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    r_after_bad = rsp_valid_o || !req_ready_o || busy_o || strobe_o;
  endtask

  task automatic test_reset;
    @(negedge clk_i);
    vectors++; if ({strobe_o, rsp_valid_o, rsp_err_o, we_o, busy_o, irq_status_valid_o} !== 6'b0) begin
      miscompares++; $display("FAIL reset_flags: got %b expected 000000", {strobe_o, rsp_valid_o, rsp_err_o, we_o, busy_o, irq_status_valid_o}); end
    vectors++; if ({rsp_data_o, address_o, data_o, irq_status_o} !== 32'h0) begin
      miscompares++; $display("FAIL reset_buses: got %h expected 00000000", {rsp_data_o, address_o, data_o, irq_status_o}); end
    rst_i = 1'b0;
    @(negedge clk_i);
    vectors++; if (req_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL reset_ready: got %b expected 1", req_ready_o); end
  endtask

  // Shared result checks are written out per scenario, so each test names its own failures.
  task automatic test_write;
    run_txn(8'h01, 8'h5A, 1'b1, 3, 8'hEE, 0);
    vectors++; if (r_hung || r_stable_bad) begin
      miscompares++; $display("FAIL write_bus: hung=%b unstable=%b expected 0 0", r_hung, r_stable_bad); end
    vectors++; if (r_scount != 3 || r_lat != 4) begin
      miscompares++; $display("FAIL write_timing: strobe=%0d lat=%0d expected 3 4", r_scount, r_lat); end
    vectors++; if (r_data !== 8'h00 || r_err !== 1'b0) begin
      miscompares++; $display("FAIL write_rsp: data=%h err=%b expected 00 0", r_data, r_err); end
    vectors++; if (r_ready_at_req !== 1'b1 || r_after_bad) begin
      miscompares++; $display("FAIL write_handshake: ready=%b after_bad=%b expected 1 0", r_ready_at_req, r_after_bad); end
  endtask

  task automatic test_read_hold;
    run_txn(8'h0A, 8'h00, 1'b0, 2, 8'hC3, 5);
    vectors++; if (r_hung || r_data !== 8'hC3 || r_err !== 1'b0) begin
      miscompares++; $display("FAIL read_rsp: hung=%b data=%h err=%b expected 0 c3 0", r_hung, r_data, r_err); end
    vectors++; if (r_hold_bad || r_after_bad) begin
      miscompares++; $display("FAIL read_hold: hold_bad=%b after_bad=%b expected 0 0", r_hold_bad, r_after_bad); end
  endtask

  task automatic test_timeout;
    int lats [3] = '{0, TO, TO + 1};
    for (int i = 0; i < 3; i++) begin
      logic exp_err;
      int   exp_sc;
      exp_err = (lats[i] == 0 || lats[i] > TO);
      exp_sc  = exp_err ? TO : lats[i];
      run_txn(8'h30 + 8'(i), 8'h00, 1'b0, lats[i], 8'h6B, 1);
      vectors++; if (r_hung || r_scount != exp_sc || r_rises != 1) begin
        miscompares++; $display("FAIL timeout_strobe[%0d]: hung=%b strobe=%0d rises=%0d expected 0 %0d 1", i, r_hung, r_scount, r_rises, exp_sc); end
      vectors++; if (r_err !== exp_err || r_data !== (exp_err ? 8'hFF : 8'h6B)) begin
        miscompares++; $display("FAIL timeout_rsp[%0d]: err=%b data=%h expected %b %h", i, r_err, r_data, exp_err, exp_err ? 8'hFF : 8'h6B); end
    end
    run_txn(8'h40, 8'h99, 1'b1, 1, 8'h00, 0);
    vectors++; if (r_hung || r_err !== 1'b0 || r_data !== 8'h00 || r_scount != 1) begin
      miscompares++; $display("FAIL timeout_recover: err=%b data=%h strobe=%0d expected 0 00 1", r_err, r_data, r_scount); end
  endtask

  task automatic test_reset_mid;
    logic rsp_seen = 1'b0;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_addr_i = 8'h44; req_data_i = 8'h12; req_we_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    vectors++; if (strobe_o !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_pre: strobe=%b expected 1", strobe_o); end
    rst_i = 1'b1;
    #1;
    vectors++; if (strobe_o !== 1'b0 || busy_o !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_drop: strobe=%b busy=%b expected 0 0", strobe_o, busy_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (5) begin
      @(negedge clk_i);
      if (rsp_valid_o || strobe_o) rsp_seen = 1'b1;
    end
    vectors++; if (rsp_seen || req_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_after: activity=%b ready=%b expected 0 1", rsp_seen, req_ready_o); end
  endtask

  task automatic test_spurious_ack;
    logic bad = 1'b0;
    int   s_cyc = 0, r_cyc = 0;
    logic [7:0] got = 8'h00;
    ack_i = 1'b1;
    repeat (10) begin
      @(negedge clk_i);
      if (rsp_valid_o || busy_o || strobe_o) bad = 1'b1;
    end
    vectors++; if (bad) begin
      miscompares++; $display("FAIL spurious_idle: activity=%b expected 0", bad); end
    // Stuck-high ack through a whole access must still complete only once.
    data_i = 8'h77; rsp_ready_i = 1'b1;
    req_valid_i = 1'b1; req_addr_i = 8'h22; req_we_i = 1'b0;
    repeat (10) begin
      @(negedge clk_i);
      req_valid_i = 1'b0;
      if (strobe_o) s_cyc++;
      if (rsp_valid_o) begin r_cyc++; got = rsp_data_o; end
    end
    ack_i = 1'b0; rsp_ready_i = 1'b0;
    vectors++; if (s_cyc != 1 || r_cyc != 1 || got !== 8'h77) begin
      miscompares++; $display("FAIL stuck_ack: strobes=%0d rsps=%0d data=%h expected 1 1 77", s_cyc, r_cyc, got); end
    run_txn(8'h0B, 8'h00, 1'b0, 3, 8'h3C, 0);
    vectors++; if (r_hung || r_scount != 3 || r_data !== 8'h3C || r_err !== 1'b0) begin
      miscompares++; $display("FAIL spurious_follow: strobe=%0d data=%h err=%b expected 3 3c 0", r_scount, r_data, r_err); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 24; n++) begin
      logic [7:0] a, wd, rd, exp_d;
      logic       w, exp_err;
      int         al, rdl, exp_sc;
      a = 8'($urandom); wd = 8'($urandom); rd = 8'($urandom); w = 1'($urandom);
      al = $urandom_range(0, TO + 2); rdl = $urandom_range(0, 3);
      exp_err = (al == 0) || (al > TO);
      exp_sc  = exp_err ? TO : al;
      exp_d   = exp_err ? 8'hFF : (w ? 8'h00 : rd);
      run_txn(a, wd, w, al, rd, rdl);
      vectors++; if (r_hung || r_stable_bad || r_rises != 1) begin
        miscompares++; $display("FAIL rand_bus[%0d]: hung=%b unstable=%b rises=%0d expected 0 0 1", n, r_hung, r_stable_bad, r_rises); end
      vectors++; if (r_scount != exp_sc || r_lat != exp_sc + 1) begin
        miscompares++; $display("FAIL rand_timing[%0d]: strobe=%0d lat=%0d expected %0d %0d", n, r_scount, r_lat, exp_sc, exp_sc + 1); end
      vectors++; if (r_data !== exp_d || r_err !== exp_err) begin
        miscompares++; $display("FAIL rand_rsp[%0d]: data=%h err=%b expected %h %b", n, r_data, r_err, exp_d, exp_err); end
      vectors++; if (r_hold_bad || r_after_bad || r_ready_at_req !== 1'b1) begin
        miscompares++; $display("FAIL rand_handshake[%0d]: hold_bad=%b after_bad=%b ready=%b expected 0 0 1", n, r_hold_bad, r_after_bad, r_ready_at_req); end
    end
  endtask

`ifdef USB_REG_SEQ_IRQ_FETCH_EN
  logic [7:0] m_addr [4];
  logic [7:0] m_wd [4];
  logic       m_we [4];
  int         m_acc, m_pulse, m_rsp;
  logic [7:0] m_status, m_rdata;

  // Wrapper model that logs every strobe pulse and counts status/response events.
  task automatic irq_mon(input int cycles, input int ack_lat);
    logic prev = 1'b0;
    int   sc = 0;
    m_acc = 0; m_pulse = 0; m_rsp = 0; m_status = 8'h00; m_rdata = 8'h00;
    repeat (cycles) begin
      @(negedge clk_i);
      req_valid_i = 1'b0;
      if (strobe_o && !prev) begin
        if (m_acc < 4) begin m_addr[m_acc] = address_o; m_we[m_acc] = we_o; m_wd[m_acc] = data_o; end
        m_acc++; sc = 0;
      end
      if (strobe_o) sc++;
      ack_i = strobe_o && (sc == ack_lat);
      if (irq_status_valid_o) begin m_pulse++; m_status = irq_status_o; irq_i = 1'b0; end
      if (rsp_valid_o) begin m_rsp++; m_rdata = rsp_data_o; end
      if (ack_lat == 0 && strobe_o) irq_i = 1'b0;
      prev = strobe_o;
    end
    ack_i = 1'b0; irq_i = 1'b0;
  endtask

  task automatic test_irq_fetch;
    data_i = 8'h05;
    @(negedge clk_i);
    irq_i = 1'b1;
    irq_mon(16, 2);
    vectors++; if (m_acc != 2 || m_addr[0] !== 8'h09 || m_we[0] !== 1'b0) begin
      miscompares++; $display("FAIL irq_read: accesses=%0d addr=%h we=%b expected 2 09 0", m_acc, m_addr[0], m_we[0]); end
    vectors++; if (m_addr[1] !== 8'h09 || m_we[1] !== 1'b1 || m_wd[1] !== 8'h05) begin
      miscompares++; $display("FAIL irq_write: addr=%h we=%b data=%h expected 09 1 05", m_addr[1], m_we[1], m_wd[1]); end
    vectors++; if (m_pulse != 1 || m_status !== 8'h05 || irq_status_o !== 8'h05 || m_rsp != 0) begin
      miscompares++; $display("FAIL irq_status: pulses=%0d status=%h now=%h rsps=%0d expected 1 05 05 0", m_pulse, m_status, irq_status_o, m_rsp); end
  endtask

  task automatic test_irq_priority;
    data_i = 8'h05; rsp_ready_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_addr_i = 8'h33; req_we_i = 1'b0; irq_i = 1'b1;
    irq_mon(24, 2);
    rsp_ready_i = 1'b0;
    vectors++; if (m_acc != 3 || m_addr[0] !== 8'h33 || m_addr[1] !== 8'h09 || m_addr[2] !== 8'h09) begin
      miscompares++; $display("FAIL irq_prio_order: accesses=%0d addrs=%h %h %h expected 3 33 09 09", m_acc, m_addr[0], m_addr[1], m_addr[2]); end
    vectors++; if (m_rsp != 1 || m_rdata !== 8'h05 || m_pulse != 1) begin
      miscompares++; $display("FAIL irq_prio_result: rsps=%0d data=%h pulses=%0d expected 1 05 1", m_rsp, m_rdata, m_pulse); end
  endtask

  task automatic test_irq_timeout;
    data_i = 8'hA0;
    @(negedge clk_i);
    irq_i = 1'b1;
    irq_mon(14, 0);
    vectors++; if (m_acc != 1 || m_pulse != 0 || irq_status_o !== 8'h05 || busy_o !== 1'b0) begin
      miscompares++; $display("FAIL irq_timeout: accesses=%0d pulses=%0d status=%h busy=%b expected 1 0 05 0", m_acc, m_pulse, irq_status_o, busy_o); end
  endtask
`else
  task automatic test_irq_ignored;
    logic bad = 1'b0;
    @(negedge clk_i);
    irq_i = 1'b1;
    repeat (10) begin
      @(negedge clk_i);
      if (busy_o || strobe_o || irq_status_valid_o || irq_status_o !== 8'h00) bad = 1'b1;
    end
    irq_i = 1'b0;
    vectors++; if (bad) begin
      miscompares++; $display("FAIL irq_disabled: activity=%b expected 0", bad); end
  endtask
`endif

  initial begin
    test_reset;
    test_write;
    test_read_hold;
    test_timeout;
    test_reset_mid;
    test_spurious_ack;
    test_random;
`ifdef USB_REG_SEQ_IRQ_FETCH_EN
    test_irq_fetch;
    test_irq_priority;
    test_irq_timeout;
`else
    test_irq_ignored;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
